// File: rtl/alu_sequencer_pkg.sv
// Shared CPU package for the ALU sequencer.
// Holds the datapath width, the ALU opcode encodings and the sequencer
// FSM state encoding. Both the sequencer and its register file import it.
package alu_sequencer_pkg;

  // Datapath width of the combinational ALU
  localparam int W = 8;

  // ALU select encodings driven on alu_sel_o
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Sequencer FSM: accept -> operands stable -> sample result -> write back
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_WB      = 2'b11
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU sequencer.
// NREG x W storage with one synchronous write port and three combinational
// read ports (two operand ports, one external observation port).
// Ports:
//   clk, rst              clock, asynchronous active-high reset (clears all entries)
//   we_i/waddr_i/wdata_i  single write port; the caller decides writeback vs ld priority
//   raddr_a_i/rdata_a_o   operand A read
//   raddr_b_i/rdata_b_o   operand B read
//   raddr_r_i/rdata_r_o   external read
module alu_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = alu_sequencer_pkg::W,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  input  logic [AW-1:0] raddr_r_i,
  output logic [W-1:0]  rdata_a_o,
  output logic [W-1:0]  rdata_b_o,
  output logic [W-1:0]  rdata_r_o
);

  logic [W-1:0] regs_q [NREG];

  // Storage: cleared on reset, one write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads have no write bypass: a write shows up only after its edge
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
  assign rdata_r_o = regs_q[raddr_r_i];

endmodule

// File: rtl/alu_sequencer.sv
// Sequential front end for the 8-bit combinational ALU.
// Accepts one operation at a time over req_valid_i/req_ready_o, presents the
// selected registers to the ALU from registered outputs, samples the ALU
// result and flags, then writes the result back into the register file.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid_i/req_ready_o           request handshake (ready only in IDLE)
//   req_op_i, req_src_a_i/b_i, req_dst_i   operation and register indices
//   ld_en_i/ld_addr_i/ld_data_i       external register-file write
//   rd_addr_i/rd_data_o               combinational register-file read
//   alu_r0_o/alu_r1_o/alu_sel_o       registered operands and select to the ALU
//   alu_r2_i/alu_overflow_i/alu_borrowflag_i   ALU result and flags
//   done_o                            one-cycle pulse while the result is written back
//   flag_ovf_o/flag_brw_o             flags of the last completed operation
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = alu_sequencer_pkg::W,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [AW-1:0] req_src_a_i,
  input  logic [AW-1:0] req_src_b_i,
  input  logic [AW-1:0] req_dst_i,
  input  logic          ld_en_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [W-1:0]  ld_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o,
  output logic [W-1:0]  alu_r0_o,
  output logic [W-1:0]  alu_r1_o,
  output logic [1:0]    alu_sel_o,
  input  logic [W-1:0]  alu_r2_i,
  input  logic          alu_overflow_i,
  input  logic          alu_borrowflag_i,
  output logic          done_o,
  output logic          flag_ovf_o,
  output logic          flag_brw_o
);

  state_e        state_q;
  logic          req_ready_q;
  logic          done_q;
  logic [AW-1:0] dst_q;
  logic [W-1:0]  alu_r0_q;
  logic [W-1:0]  alu_r1_q;
  logic [1:0]    alu_sel_q;
  logic [W-1:0]  res_q;
  logic          ovf_cap_q;
  logic          brw_cap_q;
  logic          flag_ovf_q;
  logic          flag_brw_q;

  logic          wb_active;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;
  logic [W-1:0]  rf_rdata_a;
  logic [W-1:0]  rf_rdata_b;

  // The register file has a single write port. During WB the writeback owns
  // it, so an ld strobe in that cycle is dropped (in particular an ld to dst
  // can never overwrite the result).
  assign wb_active = (state_q == ST_WB);
  assign rf_we     = wb_active | ld_en_i;
  assign rf_waddr  = wb_active ? dst_q : ld_addr_i;
  assign rf_wdata  = wb_active ? res_q : ld_data_i;

  alu_regfile #(
    .NREG (NREG),
    .W    (W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (req_src_a_i),
    .raddr_b_i (req_src_b_i),
    .raddr_r_i (rd_addr_i),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b),
    .rdata_r_o (rd_data_o)
  );

  // Sequencer FSM with registered outputs. Operands are copied out of the
  // register file at acceptance, so later ld writes or a dst that aliases a
  // source cannot disturb the operation in flight. ALU drive registers only
  // change at acceptance and hold their values while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      dst_q       <= '0;
      alu_r0_q    <= '0;
      alu_r1_q    <= '0;
      alu_sel_q   <= OP_ADD;
      res_q       <= '0;
      ovf_cap_q   <= 1'b0;
      brw_cap_q   <= 1'b0;
      flag_ovf_q  <= 1'b0;
      flag_brw_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            alu_r0_q    <= rf_rdata_a;
            alu_r1_q    <= rf_rdata_b;
            alu_sel_q   <= req_op_i;
            dst_q       <= req_dst_i;
            req_ready_q <= 1'b0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          res_q     <= alu_r2_i;
          ovf_cap_q <= alu_overflow_i;
          brw_cap_q <= alu_borrowflag_i;
          done_q    <= 1'b1;
          state_q   <= ST_WB;
        end
        ST_WB: begin
          flag_ovf_q  <= ovf_cap_q;
          flag_brw_q  <= brw_cap_q;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign done_o      = done_q;
  assign alu_r0_o    = alu_r0_q;
  assign alu_r1_o    = alu_r1_q;
  assign alu_sel_o   = alu_sel_q;
  assign flag_ovf_o  = flag_ovf_q;
  assign flag_brw_o  = flag_brw_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. A behavioural ALU closes the
// r0/r1/sel -> r2/overflow/borrowflag loop; directed vectors carry
// hand-computed results, followed by a random run against a register model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int NREG = 4;
  localparam int AW   = 2;

  logic          clk;
  logic          rst;
  logic          reqValid;
  logic          reqReady;
  logic [1:0]    reqOp;
  logic [AW-1:0] reqSrcA;
  logic [AW-1:0] reqSrcB;
  logic [AW-1:0] reqDst;
  logic          ldEn;
  logic [AW-1:0] ldAddr;
  logic [W-1:0]  ldData;
  logic [AW-1:0] rdAddr;
  logic [W-1:0]  rdData;
  logic [W-1:0]  aluR0;
  logic [W-1:0]  aluR1;
  logic [1:0]    aluSel;
  logic [W-1:0]  aluR2;
  logic          aluOvf;
  logic          aluBrw;
  logic          done;
  logic          flagOvf;
  logic          flagBrw;

  int compareCount = 0;
  int mismatchCount = 0;

  alu_sequencer #(.NREG(NREG), .W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (reqValid),
    .req_ready_o      (reqReady),
    .req_op_i         (reqOp),
    .req_src_a_i      (reqSrcA),
    .req_src_b_i      (reqSrcB),
    .req_dst_i        (reqDst),
    .ld_en_i          (ldEn),
    .ld_addr_i        (ldAddr),
    .ld_data_i        (ldData),
    .rd_addr_i        (rdAddr),
    .rd_data_o        (rdData),
    .alu_r0_o         (aluR0),
    .alu_r1_o         (aluR1),
    .alu_sel_o        (aluSel),
    .alu_r2_i         (aluR2),
    .alu_overflow_i   (aluOvf),
    .alu_borrowflag_i (aluBrw),
    .done_o           (done),
    .flag_ovf_o       (flagOvf),
    .flag_brw_o       (flagBrw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU semantics: {overflow, borrowflag, result}
  function automatic logic [W+1:0] refAlu(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         ovf;
    logic         brw;
    ovf = 1'b0;
    brw = 1'b0;
    s   = '0;
    case (op)
      OP_ADD: begin
        s   = {1'b0, a} + {1'b0, b};
        r   = s[W-1:0];
        ovf = s[W];
      end
      OP_SUB: begin
        r   = a - b;
        brw = (a < b);
      end
      OP_AND: r = a & b;
      default: r = a | b;
    endcase
    return {ovf, brw, r};
  endfunction

  // Behavioural ALU attached to the sequencer's drive ports
  always_comb begin
    {aluOvf, aluBrw, aluR2} = refAlu(aluR0, aluR1, aluSel);
  end

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input logic [AW-1:0] addr, input logic [W-1:0] expected,
                          input string tag);
    rdAddr = addr;
    #1;
    checkOutput(tag, rdData, expected);
  endtask

  // Called just after a falling edge; the write lands on the next rising edge
  task automatic loadReg(input logic [AW-1:0] addr, input logic [W-1:0] data);
    ldEn   = 1'b1;
    ldAddr = addr;
    ldData = data;
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  // Issues one request from IDLE and checks operands, done latency, result and flags.
  // ldPhase: 0 none, 1 ld during ISSUE, 2 ld during WB.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] srcA,
                               input logic [AW-1:0] srcB, input logic [AW-1:0] dst,
                               input logic [W-1:0] expA, input logic [W-1:0] expB,
                               input logic [W-1:0] expR, input logic expOvf,
                               input logic expBrw, input int ldPhase,
                               input logic [AW-1:0] ldA, input logic [W-1:0] ldD);
    int cycles;
    checkOutput("ready_before_req", reqReady, 1);
    reqValid = 1'b1;
    reqOp    = op;
    reqSrcA  = srcA;
    reqSrcB  = srcB;
    reqDst   = dst;
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("ready_after_accept", reqReady, 0);
    checkOutput("alu_r0", aluR0, expA);
    checkOutput("alu_r1", aluR1, expB);
    checkOutput("alu_sel", aluSel, op);
    if (ldPhase == 1) begin
      ldEn   = 1'b1;
      ldAddr = ldA;
      ldData = ldD;
    end
    cycles = 0;
    while (!done && cycles < 8) begin
      @(negedge clk);
      cycles++;
      if (ldPhase == 1 && cycles == 1) ldEn = 1'b0;
    end
    checkOutput("done_latency", cycles, 2);
    if (ldPhase == 2) begin
      ldEn   = 1'b1;
      ldAddr = ldA;
      ldData = ldD;
    end
    @(negedge clk);
    ldEn = 1'b0;
    checkOutput("done_single_cycle", done, 0);
    checkOutput("ready_after_done", reqReady, 1);
    checkOutput("flag_ovf", flagOvf, expOvf);
    checkOutput("flag_brw", flagBrw, expBrw);
    checkReg(dst, expR, "result_reg");
  endtask

  logic [W-1:0] mdl [NREG];

  initial begin
    logic [W+1:0] e;
    logic [1:0]   op;
    logic [AW-1:0] sa, sb, dd;
    logic         readyExp [9];
    logic         doneExp [9];
    int           doneSeen;

    rst = 1'b1; reqValid = 1'b0; reqOp = '0; reqSrcA = '0; reqSrcB = '0; reqDst = '0;
    ldEn = 1'b0; ldAddr = '0; ldData = '0; rdAddr = '0;

    // Reset state
    #2;
    checkOutput("rst_ready", reqReady, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_alu_r0", aluR0, 0);
    checkOutput("rst_alu_sel", aluSel, 0);
    checkOutput("rst_flags", {flagOvf, flagBrw}, 0);
    for (int i = 0; i < NREG; i++) checkReg(i[AW-1:0], 8'h00, "rst_reg");
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic and logic vectors
    loadReg(2'd0, 8'h6A);
    loadReg(2'd1, 8'hE2);
    checkReg(2'd0, 8'h6A, "ld_r0");
    checkReg(2'd1, 8'hE2, "ld_r1");
    applyStimulus(OP_ADD, 2'd0, 2'd1, 2'd2, 8'h6A, 8'hE2, 8'h4C, 1'b1, 1'b0, 0, 2'd0, 8'h00);
    applyStimulus(OP_SUB, 2'd0, 2'd1, 2'd3, 8'h6A, 8'hE2, 8'h88, 1'b0, 1'b1, 0, 2'd0, 8'h00);
    applyStimulus(OP_AND, 2'd0, 2'd1, 2'd0, 8'h6A, 8'hE2, 8'h62, 1'b0, 1'b0, 0, 2'd0, 8'h00);
    applyStimulus(OP_OR,  2'd1, 2'd1, 2'd1, 8'hE2, 8'hE2, 8'hE2, 1'b0, 1'b0, 0, 2'd0, 8'h00);

    // Back-to-back with req_valid held: r0=62 r1=E2 r2=4C r3=88
    readyExp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    doneExp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reqValid = 1'b1; reqOp = OP_ADD; reqSrcA = 2'd2; reqSrcB = 2'd3; reqDst = 2'd0;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("b2b_ready[%0d]", i), reqReady, readyExp[i]);
      checkOutput($sformatf("b2b_done[%0d]", i), done, doneExp[i]);
      if (i == 1) begin
        checkOutput("b2b_op1_r0", aluR0, 8'h4C);
        checkOutput("b2b_op1_r1", aluR1, 8'h88);
        reqOp = OP_SUB; reqSrcA = 2'd0; reqSrcB = 2'd1; reqDst = 2'd3;
      end
      if (i == 2) checkOutput("b2b_busy_ignored", aluSel, OP_ADD);
      if (i == 5) begin
        checkOutput("b2b_op2_r0", aluR0, 8'hD4);
        checkOutput("b2b_op2_r1", aluR1, 8'hE2);
        checkOutput("b2b_op2_sel", aluSel, OP_SUB);
        reqValid = 1'b0;
      end
      if (i < 8) @(negedge clk);
    end
    checkOutput("b2b_flags", {flagOvf, flagBrw}, 2'b01);
    checkReg(2'd0, 8'hD4, "b2b_r0");
    checkReg(2'd3, 8'hF2, "b2b_r3");

    // ld to a source during ISSUE: operation keeps the latched operand
    applyStimulus(OP_SUB, 2'd1, 2'd0, 2'd3, 8'hE2, 8'hD4, 8'h0E, 1'b0, 1'b0, 1, 2'd1, 8'h10);
    checkReg(2'd1, 8'h10, "issue_ld_kept");

    // ld to dst during WB: writeback wins
    applyStimulus(OP_ADD, 2'd0, 2'd0, 2'd2, 8'hD4, 8'hD4, 8'hA8, 1'b1, 1'b0, 2, 2'd2, 8'h55);

    // Reset asserted in CAPTURE aborts the operation
    reqValid = 1'b1; reqOp = OP_ADD; reqSrcA = 2'd2; reqSrcB = 2'd3; reqDst = 2'd1;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_ready", reqReady, 1);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_alu_r0", aluR0, 0);
    checkOutput("abort_alu_r1", aluR1, 0);
    checkOutput("abort_alu_sel", aluSel, 0);
    checkOutput("abort_flags", {flagOvf, flagBrw}, 0);
    for (int i = 0; i < NREG; i++) checkReg(i[AW-1:0], 8'h00, "abort_reg");
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);
    checkOutput("abort_ready_after", reqReady, 1);
    checkReg(2'd1, 8'h00, "abort_no_wb");

    // Random operations against the register model
    for (int i = 0; i < NREG; i++) begin
      mdl[i] = W'($urandom);
      loadReg(i[AW-1:0], mdl[i]);
    end
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(3) == 0) begin
        dd = AW'($urandom);
        mdl[dd] = W'($urandom);
        loadReg(dd, mdl[dd]);
      end
      op = 2'($urandom);
      sa = AW'($urandom);
      sb = AW'($urandom);
      dd = AW'($urandom);
      e  = refAlu(mdl[sa], mdl[sb], op);
      applyStimulus(op, sa, sb, dd, mdl[sa], mdl[sb], e[W-1:0], e[W+1], e[W], 0, 2'd0, 8'h00);
      mdl[dd] = e[W-1:0];
    end
    for (int i = 0; i < NREG; i++) checkReg(i[AW-1:0], mdl[i], "final_reg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  // Hard stop if the stimulus ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
